writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_writeback_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
//
// Purpose:
//   Final writeback stage that merges two sources of register-file writes:
//     * the in-order pipeline, which is never stalled and always wins the
//       writeback slot, and
//     * a long-latency unit (e.g. divider), whose results are buffered in a
//       small FIFO and drained whenever the pipeline leaves the slot free.
//   It also keeps a per-register "pending write" scoreboard. Issue logic uses
//   this scoreboard to avoid launching two long-latency operations to the
//   same destination.
//
// Ports:
//   clk_i            clock, all state changes on the rising edge
//   rst_ni           asynchronous active-low reset
//   pipe_valid_i     pipeline instruction present at writeback
//   pipe_rd_wr_en_i  pipeline instruction writes rd
//   pipe_rd_idx_i    pipeline destination index
//   pipe_rd_data_i   pipeline write data
//   lu_valid_i       long-latency result valid
//   lu_ready_o       result buffer can accept a result (registered count only)
//   lu_rd_idx_i      long-latency destination index
//   lu_rd_data_i     long-latency result data
//   issue_valid_i    long-latency operation issued this cycle
//   issue_rd_idx_i   destination of the issued operation
//   issue_ready_o    issue destination is not already pending
//   busy_o           per-register pending-write scoreboard (bit 0 always 0)
//   WB_valid_o       writeback slot occupied
//   WB_rd_wr_en_o    register file write enable / forwarding enable
//   WB_rd_idx_o      register file write index
//   WB_rd_data_o     register file write data
//
// Parameter:
//   DEPTH            long-latency result buffer depth, legal range 2..4
// ---------------------------------------------------------------------------

// Data width normally comes from Lucid64.vh; this fallback keeps the block
// self-contained when that header has not already defined it.
`ifndef XLEN
`define XLEN 64
`endif

module writeback_unit #(
    parameter int DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic               pipe_valid_i,
    input  logic               pipe_rd_wr_en_i,
    input  logic [4:0]         pipe_rd_idx_i,
    input  logic [`XLEN-1:0]   pipe_rd_data_i,

    input  logic               lu_valid_i,
    output logic               lu_ready_o,
    input  logic [4:0]         lu_rd_idx_i,
    input  logic [`XLEN-1:0]   lu_rd_data_i,

    input  logic               issue_valid_i,
    input  logic [4:0]         issue_rd_idx_i,
    output logic               issue_ready_o,
    output logic [31:0]        busy_o,

    output logic               WB_valid_o,
    output logic               WB_rd_wr_en_o,
    output logic [4:0]         WB_rd_idx_o,
    output logic [`XLEN-1:0]   WB_rd_data_o
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    // -----------------------------------------------------------------------
    // Result buffer storage. The arrays carry no reset: an entry is only ever
    // read while the registered count says it holds valid data.
    // -----------------------------------------------------------------------
    logic [4:0]         fifo_idx_mem  [DEPTH];
    logic [`XLEN-1:0]   fifo_data_mem [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic               wb_valid_q,    wb_valid_d;
    logic               wb_wr_en_q,    wb_wr_en_d;
    logic [4:0]         wb_idx_q,      wb_idx_d;
    logic [`XLEN-1:0]   wb_data_q,     wb_data_d;

    logic [31:0]        busy_q, busy_d;

    logic               pipe_fire;
    logic               lu_push;
    logic               lu_pop;
    logic [4:0]         head_idx;
    logic [`XLEN-1:0]   head_data;
    logic               issue_set;
    logic [31:0]        busy_set;
    logic [31:0]        busy_clr;

    // Pointers wrap explicitly so that non power-of-two depths (3) work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    assign pipe_fire  = pipe_valid_i & pipe_rd_wr_en_i;

    // Readiness is derived from the registered count only; a pop happening in
    // the same cycle does not open a full buffer, which keeps lu_ready_o off
    // the pipe_fire timing path.
    assign lu_ready_o = (count_q < CNT_DEPTH);
    assign lu_push    = lu_valid_i & lu_ready_o;

    // The head drains only when the pipeline does not claim the slot. Because
    // the pop looks at count_q, an entry pushed this cycle cannot be popped
    // until the next one: there is no bypass around the buffer.
    assign lu_pop     = ~pipe_fire & (count_q != '0);

    assign head_idx   = fifo_idx_mem[rd_ptr_q];
    assign head_data  = fifo_data_mem[rd_ptr_q];

    // -----------------------------------------------------------------------
    // Buffer bookkeeping
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (lu_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (lu_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({lu_push, lu_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (lu_push) begin
            fifo_idx_mem[wr_ptr_q]  <= lu_rd_idx_i;
            fifo_data_mem[wr_ptr_q] <= lu_rd_data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Writeback slot selection
    // -----------------------------------------------------------------------
    always_comb begin
        // A valid pipeline instruction occupies the slot even if it does not
        // write rd; index/data only change when a real write is selected.
        wb_valid_d = pipe_valid_i | lu_pop;
        wb_wr_en_d = 1'b0;
        wb_idx_d   = wb_idx_q;
        wb_data_d  = wb_data_q;

        if (pipe_fire) begin
            wb_wr_en_d = (pipe_rd_idx_i != 5'd0);
            wb_idx_d   = pipe_rd_idx_i;
            wb_data_d  = pipe_rd_data_i;
        end else if (lu_pop) begin
            wb_wr_en_d = (head_idx != 5'd0);
            wb_idx_d   = head_idx;
            wb_data_d  = head_data;
        end
    end

    // -----------------------------------------------------------------------
    // Pending-write scoreboard
    // -----------------------------------------------------------------------
    assign issue_ready_o = ~busy_q[issue_rd_idx_i];
    assign issue_set     = issue_valid_i & issue_ready_o & (issue_rd_idx_i != 5'd0);

    // Bit 0 is tied low: x0 can never have a pending write. For the others,
    // a set on the same edge as a clear wins, since the new issue is still
    // outstanding after the old result retires.
    assign busy_set[0] = 1'b0;
    assign busy_clr[0] = 1'b0;
    assign busy_d[0]   = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            assign busy_set[gi] = issue_set & (issue_rd_idx_i == 5'(gi));
            assign busy_clr[gi] = lu_pop    & (head_idx       == 5'(gi));
            assign busy_d[gi]   = busy_set[gi] | (busy_q[gi] & ~busy_clr[gi]);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_wr_en_q <= 1'b0;
            wb_idx_q   <= '0;
            wb_data_q  <= '0;
            busy_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wb_valid_q <= wb_valid_d;
            wb_wr_en_q <= wb_wr_en_d;
            wb_idx_q   <= wb_idx_d;
            wb_data_q  <= wb_data_d;
            busy_q     <= busy_d;
        end
    end

    assign busy_o        = busy_q;
    assign WB_valid_o    = wb_valid_q;
    assign WB_rd_wr_en_o = wb_wr_en_q;
    assign WB_rd_idx_o   = wb_idx_q;
    assign WB_rd_data_o  = wb_data_q;

endmodule

// File: tb/tb_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_writeback_unit
//
// Directed testbench for writeback_unit (DEPTH = 2). Inputs are driven 1 ns
// after a rising edge; outputs are checked 1 ns after the edge that should
// have produced them (or mid-cycle for combinational outputs).
// ---------------------------------------------------------------------------

`ifndef XLEN
`define XLEN 64
`endif

module tb_writeback_unit;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               pipe_valid_i;
    logic               pipe_rd_wr_en_i;
    logic [4:0]         pipe_rd_idx_i;
    logic [`XLEN-1:0]   pipe_rd_data_i;
    logic               lu_valid_i;
    logic               lu_ready_o;
    logic [4:0]         lu_rd_idx_i;
    logic [`XLEN-1:0]   lu_rd_data_i;
    logic               issue_valid_i;
    logic [4:0]         issue_rd_idx_i;
    logic               issue_ready_o;
    logic [31:0]        busy_o;
    logic               WB_valid_o;
    logic               WB_rd_wr_en_o;
    logic [4:0]         WB_rd_idx_o;
    logic [`XLEN-1:0]   WB_rd_data_o;

    int n_pass  = 0;
    int n_total = 0;

    writeback_unit #(.DEPTH(2)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .pipe_valid_i    (pipe_valid_i),
        .pipe_rd_wr_en_i (pipe_rd_wr_en_i),
        .pipe_rd_idx_i   (pipe_rd_idx_i),
        .pipe_rd_data_i  (pipe_rd_data_i),
        .lu_valid_i      (lu_valid_i),
        .lu_ready_o      (lu_ready_o),
        .lu_rd_idx_i     (lu_rd_idx_i),
        .lu_rd_data_i    (lu_rd_data_i),
        .issue_valid_i   (issue_valid_i),
        .issue_rd_idx_i  (issue_rd_idx_i),
        .issue_ready_o   (issue_ready_o),
        .busy_o          (busy_o),
        .WB_valid_o      (WB_valid_o),
        .WB_rd_wr_en_o   (WB_rd_wr_en_o),
        .WB_rd_idx_o     (WB_rd_idx_o),
        .WB_rd_data_o    (WB_rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
            $error("check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pipe(input logic v, input logic we, input logic [4:0] idx, input logic [63:0] d);
        pipe_valid_i    = v;
        pipe_rd_wr_en_i = we;
        pipe_rd_idx_i   = idx;
        pipe_rd_data_i  = `XLEN'(d);
    endtask

    task automatic lu(input logic v, input logic [4:0] idx, input logic [63:0] d);
        lu_valid_i   = v;
        lu_rd_idx_i  = idx;
        lu_rd_data_i = `XLEN'(d);
    endtask

    task automatic check_wb(input string tag, input logic v, input logic we,
                            input logic [4:0] idx, input logic [63:0] d);
        chk({tag, ".valid"}, 64'(WB_valid_o),    64'(v));
        chk({tag, ".wr_en"}, 64'(WB_rd_wr_en_o), 64'(we));
        chk({tag, ".idx"},   64'(WB_rd_idx_o),   64'(idx));
        chk({tag, ".data"},  64'(WB_rd_data_o),  d);
        $display("[%0t] %s: WB v=%0b we=%0b idx=%0d data=0x%0h busy=0x%08h lu_ready=%0b",
                 $time, tag, WB_valid_o, WB_rd_wr_en_o, WB_rd_idx_o, WB_rd_data_o, busy_o, lu_ready_o);
    endtask

    initial begin
        rst_ni = 1'b0;
        pipe(1'b0, 1'b0, 5'd0, 64'h0);
        lu(1'b0, 5'd0, 64'h0);
        issue_valid_i  = 1'b0;
        issue_rd_idx_i = 5'd0;

        // ---------------- reset state ----------------
        #2;
        check_wb("reset", 1'b0, 1'b0, 5'd0, 64'h0);
        chk("reset.busy",        64'(busy_o),        64'h0);
        chk("reset.lu_ready",    64'(lu_ready_o),    64'h1);
        chk("reset.issue_ready", 64'(issue_ready_o), 64'h1);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("idle.valid", 64'(WB_valid_o), 64'h0);

        // ---------------- pipe write, 1-cycle latency ----------------
        pipe(1'b1, 1'b1, 5'd5, 64'hAA);
        tick();
        pipe(1'b0, 1'b0, 5'd0, 64'h0);
        check_wb("pipe5", 1'b1, 1'b1, 5'd5, 64'hAA);
        tick();
        // Idle slot: enable drops, index/data hold.
        check_wb("hold", 1'b0, 1'b0, 5'd5, 64'hAA);

        // ---------------- issue idx 7, then LU result ----------------
        issue_valid_i  = 1'b1;
        issue_rd_idx_i = 5'd7;
        #1;
        chk("iss7.ready_before", 64'(issue_ready_o), 64'h1);
        tick();
        issue_valid_i = 1'b0;
        chk("iss7.busy",        64'(busy_o),        64'h80);
        chk("iss7.ready_after", 64'(issue_ready_o), 64'h0);
        lu(1'b1, 5'd7, 64'h1234);
        tick();
        lu(1'b0, 5'd0, 64'h0);
        chk("lu7.no_bypass", 64'(WB_valid_o), 64'h0);
        chk("lu7.busy_mid",  64'(busy_o),     64'h80);
        chk("lu7.lu_ready",  64'(lu_ready_o), 64'h1);
        tick();
        check_wb("lu7", 1'b1, 1'b1, 5'd7, 64'h1234);
        chk("lu7.busy_clr", 64'(busy_o), 64'h0);

        // ---------------- pipe priority, buffer fills ----------------
        pipe(1'b1, 1'b1, 5'd10, 64'h100);
        lu(1'b1, 5'd3, 64'h33);
        #1;
        chk("prio.ready0", 64'(lu_ready_o), 64'h1);
        tick();
        check_wb("prio.p10", 1'b1, 1'b1, 5'd10, 64'h100);
        pipe(1'b1, 1'b1, 5'd11, 64'h101);
        lu(1'b1, 5'd4, 64'h44);
        tick();
        lu(1'b0, 5'd0, 64'h0);
        check_wb("prio.p11", 1'b1, 1'b1, 5'd11, 64'h101);
        chk("prio.full", 64'(lu_ready_o), 64'h0);
        pipe(1'b1, 1'b1, 5'd12, 64'h102);
        tick();
        check_wb("prio.p12", 1'b1, 1'b1, 5'd12, 64'h102);
        pipe(1'b1, 1'b1, 5'd13, 64'h103);
        tick();
        pipe(1'b0, 1'b0, 5'd0, 64'h0);
        check_wb("prio.p13", 1'b1, 1'b1, 5'd13, 64'h103);
        // Pop happens this cycle, but readiness still reflects the full count.
        #1;
        chk("prio.full_during_pop", 64'(lu_ready_o), 64'h0);
        tick();
        check_wb("prio.lu3", 1'b1, 1'b1, 5'd3, 64'h33);
        chk("prio.ready_after_pop", 64'(lu_ready_o), 64'h1);
        tick();
        check_wb("prio.lu4", 1'b1, 1'b1, 5'd4, 64'h44);
        tick();
        chk("prio.drained", 64'(WB_valid_o), 64'h0);

        // ---------------- set wins over clear on idx 9 ----------------
        lu(1'b1, 5'd9, 64'h99);
        tick();
        lu(1'b0, 5'd0, 64'h0);
        issue_valid_i  = 1'b1;
        issue_rd_idx_i = 5'd9;
        #1;
        chk("iss9.ready_before", 64'(issue_ready_o), 64'h1);
        tick();
        issue_valid_i = 1'b0;
        check_wb("iss9.pop", 1'b1, 1'b1, 5'd9, 64'h99);
        chk("iss9.busy",        64'(busy_o),        64'h200);
        chk("iss9.ready_after", 64'(issue_ready_o), 64'h0);

        // ---------------- x0 writes and issues ----------------
        pipe(1'b1, 1'b1, 5'd0, 64'hFF);
        tick();
        pipe(1'b0, 1'b0, 5'd0, 64'h0);
        check_wb("x0", 1'b1, 1'b0, 5'd0, 64'hFF);
        issue_valid_i  = 1'b1;
        issue_rd_idx_i = 5'd0;
        tick();
        issue_valid_i = 1'b0;
        chk("x0.busy", 64'(busy_o), 64'h200);

        // ---------------- async reset with buffered entries ----------------
        issue_valid_i  = 1'b1;
        issue_rd_idx_i = 5'd3;
        pipe(1'b1, 1'b1, 5'd1, 64'h201);
        lu(1'b1, 5'd3, 64'h3333);
        tick();
        issue_valid_i = 1'b0;
        pipe(1'b1, 1'b1, 5'd2, 64'h202);
        lu(1'b1, 5'd6, 64'h6666);
        tick();
        lu(1'b0, 5'd0, 64'h0);
        chk("rst.busy_before", 64'(busy_o),     64'h208);
        chk("rst.full_before", 64'(lu_ready_o), 64'h0);
        #3;
        rst_ni = 1'b0;
        pipe(1'b0, 1'b0, 5'd0, 64'h0);
        #1;
        check_wb("rst.async", 1'b0, 1'b0, 5'd0, 64'h0);
        chk("rst.busy",     64'(busy_o),     64'h0);
        chk("rst.lu_ready", 64'(lu_ready_o), 64'h1);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("rst.no_stale_wb", 64'(WB_valid_o), 64'h0);
        chk("rst.busy_after",  64'(busy_o),     64'h0);
        chk("rst.ready_after", 64'(lu_ready_o), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
